// File: rtl/micro_adder_arbiter.sv
// micro_adder_arbiter: round-robin front end sharing one external adder
// between three requesters, with an operand stage and a result stage.
module micro_adder_arbiter #(
   parameter int ADDER_WIDTH = 35
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req0_valid,
   output logic                   req0_ready,
   input  logic [ADDER_WIDTH-1:0] req0_op1,
   input  logic [ADDER_WIDTH-1:0] req0_op2,
   input  logic                   req0_sub,
   input  logic                   req1_valid,
   output logic                   req1_ready,
   input  logic [ADDER_WIDTH-1:0] req1_op1,
   input  logic [ADDER_WIDTH-1:0] req1_op2,
   input  logic                   req1_sub,
   input  logic                   req2_valid,
   output logic                   req2_ready,
   input  logic [ADDER_WIDTH-1:0] req2_op1,
   input  logic [ADDER_WIDTH-1:0] req2_op2,
   input  logic                   req2_sub,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [1:0]             rsp_id,
   output logic [ADDER_WIDTH-1:0] rsp_res,
   output logic [ADDER_WIDTH-1:0] mau_adder_op1,
   output logic [ADDER_WIDTH-1:0] mau_adder_op2,
   output logic                   mau_adder_add,
   output logic                   mau_adder_sub,
   input  logic [ADDER_WIDTH-1:0] mau_adder_res,
   output logic                   busy
);

   logic                   s2_free;
   logic                   s1_adv;
   logic                   accept_en;
   logic                   accept;
   logic                   op_vld;
   logic [ADDER_WIDTH-1:0] op1;
   logic [ADDER_WIDTH-1:0] op2;
   logic                   sub;
   logic [1:0]             id;
   logic [1:0]             rr_ptr;
   logic [1:0]             next_ptr;
   logic [2:0]             valid;
   logic [2:0]             grant;
   logic [2:0]             ready;
   logic [1:0]             gid;
   logic [ADDER_WIDTH-1:0] sel_op1;
   logic [ADDER_WIDTH-1:0] sel_op2;
   logic                   sel_sub;

   assign valid     = {req2_valid, req1_valid, req0_valid};
   assign s2_free   = !rsp_valid | rsp_ready;
   assign s1_adv    = op_vld & s2_free;
   assign accept_en = !op_vld | s1_adv;

   // Search order starts at rr_ptr and wraps modulo 3.
   always_comb begin
      grant = '0;
      gid   = '0;
      case (rr_ptr)
         2'd1: begin
            if (valid[1]) begin
               grant = 3'b010;
               gid   = 2'd1;
            end else if (valid[2]) begin
               grant = 3'b100;
               gid   = 2'd2;
            end else if (valid[0]) begin
               grant = 3'b001;
               gid   = 2'd0;
            end
         end
         2'd2: begin
            if (valid[2]) begin
               grant = 3'b100;
               gid   = 2'd2;
            end else if (valid[0]) begin
               grant = 3'b001;
               gid   = 2'd0;
            end else if (valid[1]) begin
               grant = 3'b010;
               gid   = 2'd1;
            end
         end
         default: begin
            if (valid[0]) begin
               grant = 3'b001;
               gid   = 2'd0;
            end else if (valid[1]) begin
               grant = 3'b010;
               gid   = 2'd1;
            end else if (valid[2]) begin
               grant = 3'b100;
               gid   = 2'd2;
            end
         end
      endcase
   end

   // Gating with rst_n keeps every ready low while reset is held.
   assign ready      = {3{rst_n & accept_en}} & grant;
   assign req0_ready = ready[0];
   assign req1_ready = ready[1];
   assign req2_ready = ready[2];
   assign accept     = |ready;
   assign next_ptr   = (gid == 2'd2) ? 2'd0 : 2'(gid + 2'd1);

   always_comb begin
      sel_op1 = req0_op1;
      sel_op2 = req0_op2;
      sel_sub = req0_sub;
      case (gid)
         2'd1: begin
            sel_op1 = req1_op1;
            sel_op2 = req1_op2;
            sel_sub = req1_sub;
         end
         2'd2: begin
            sel_op1 = req2_op1;
            sel_op2 = req2_op2;
            sel_sub = req2_sub;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= next_ptr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_vld <= 1'b0;
         op1    <= '0;
         op2    <= '0;
         sub    <= 1'b0;
         id     <= '0;
      end else if (accept) begin
         op_vld <= 1'b1;
         op1    <= sel_op1;
         op2    <= sel_op2;
         sub    <= sel_sub;
         id     <= gid;
      end else if (s1_adv) begin
         op_vld <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_res   <= '0;
         rsp_id    <= '0;
      end else if (s1_adv) begin
         rsp_valid <= 1'b1;
         rsp_res   <= mau_adder_res;
         rsp_id    <= id;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

   // The shared adder sees all zeros whenever no operation is staged.
   assign mau_adder_op1 = op_vld ? op1 : '0;
   assign mau_adder_op2 = op_vld ? op2 : '0;
   assign mau_adder_add = op_vld & !sub;
   assign mau_adder_sub = op_vld & sub;
   assign busy          = op_vld | rsp_valid;

endmodule

// File: tb/tb_micro_adder_arbiter.sv
// tb_micro_adder_arbiter: directed and random checks of the arbiter
// against a queue-based model of in-flight operations.
module tb_micro_adder_arbiter;
   localparam int W = 35;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [2:0]   vld;
   logic [W-1:0] a [3];
   logic [W-1:0] b [3];
   logic         s [3];
   logic         r0, r1, r2;
   logic         rsp_valid, rsp_ready;
   logic [1:0]   rsp_id;
   logic [W-1:0] rsp_res;
   logic [W-1:0] m_op1, m_op2, m_res;
   logic         m_add, m_sub, busy;

   typedef struct {
      logic [W-1:0] op1;
      logic [W-1:0] op2;
      logic         sub;
      int           id;
      bit           out;
   } item_t;

   item_t      q[$];
   int         ptr;
   int         errors = 0;
   int         checks = 0;
   int         acc_cnt, rsp_cnt, obs_g;
   logic [2:0] keep;

   always #5 clk = ~clk;

   // Behavioural stand-in for the shared adder.
   assign m_res = m_add ? m_op1 + m_op2 : m_sub ? m_op1 - m_op2 : '0;

   micro_adder_arbiter #(.ADDER_WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(vld[0]), .req0_ready(r0),
      .req0_op1(a[0]), .req0_op2(b[0]), .req0_sub(s[0]),
      .req1_valid(vld[1]), .req1_ready(r1),
      .req1_op1(a[1]), .req1_op2(b[1]), .req1_sub(s[1]),
      .req2_valid(vld[2]), .req2_ready(r2),
      .req2_op1(a[2]), .req2_op2(b[2]), .req2_sub(s[2]),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_res(rsp_res),
      .mau_adder_op1(m_op1), .mau_adder_op2(m_op2),
      .mau_adder_add(m_add), .mau_adder_sub(m_sub),
      .mau_adder_res(m_res), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_res(input item_t it);
      logic [W-1:0] r;
      r = it.sub ? it.op1 - it.op2 : it.op1 + it.op2;
      return r;
   endfunction

   function automatic logic [W-1:0] rnd_op();
      logic [W-1:0] v;
      case ($urandom_range(0, 5))
         0: v = '0;
         1: v = '1;
         default: v = W'({$urandom(), $urandom()});
      endcase
      return v;
   endfunction

   task automatic new_ops(input int n);
      a[n] = rnd_op();
      b[n] = rnd_op();
      s[n] = 1'($urandom_range(0, 1));
   endtask

   // One clock: check at negedge against the model, advance the model,
   // then let the requester that was served drop or renew its request.
   task automatic cycle();
      logic [2:0] er, dr;
      int         g;
      bit         ev, s1;
      item_t      it, hd;
      @(negedge clk);
      g = -1;
      for (int k = 0; k < 3; k++)
         if (vld[(ptr + k) % 3] && g < 0) g = (ptr + k) % 3;
      er = '0;
      if (g >= 0 && (q.size() < 2 || rsp_ready)) er = 3'(1 << g);
      dr = {r2, r1, r0};
      chk("ready", 64'(dr), 64'(er));
      obs_g = dr[0] ? 0 : dr[1] ? 1 : dr[2] ? 2 : -1;
      ev = q.size() > 0 && q[0].out;
      chk("rsp_valid", 64'(rsp_valid), 64'(ev));
      chk("busy", 64'(busy), 64'(q.size() > 0));
      if (ev) begin
         chk("rsp_res", 64'(rsp_res), 64'(ref_res(q[0])));
         chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
      end
      s1 = 0;
      it = '{op1: '0, op2: '0, sub: 1'b0, id: 0, out: 1'b0};
      if (q.size() > 0 && !q[q.size() - 1].out) begin
         s1 = 1;
         it = q[q.size() - 1];
      end
      chk("mau_op1", 64'(m_op1), s1 ? 64'(it.op1) : 64'd0);
      chk("mau_op2", 64'(m_op2), s1 ? 64'(it.op2) : 64'd0);
      chk("mau_add", 64'(m_add), 64'(s1 && !it.sub));
      chk("mau_sub", 64'(m_sub), 64'(s1 && it.sub));
      if (ev && rsp_ready) begin
         void'(q.pop_front());
         rsp_cnt++;
      end
      if (q.size() > 0) begin
         hd = q[0];
         hd.out = 1;
         q[0] = hd;
      end
      if (er != 0) begin
         it.op1 = a[g];
         it.op2 = b[g];
         it.sub = s[g];
         it.id  = g;
         it.out = 0;
         q.push_back(it);
         ptr = (g + 1) % 3;
         acc_cnt++;
      end
      @(posedge clk);
      #1;
      if (er != 0) begin
         if (keep[g]) new_ops(g);
         else vld[g] = 1'b0;
      end
   endtask

   // Asynchronous reset asserted between clock edges.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      ptr = 0;
      chk("rst_ready", 64'({r2, r1, r0}), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_mau_add", 64'(m_add), 64'd0);
      chk("rst_mau_sub", 64'(m_sub), 64'd0);
      chk("rst_mau_op1", 64'(m_op1), 64'd0);
      chk("rst_rsp_res", 64'(rsp_res), 64'd0);
      chk("rst_rsp_id", 64'(rsp_id), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vld = 3'b001;
      keep = '0;
      rsp_ready = 1'b1;
      ptr = 0;
      acc_cnt = 0;
      rsp_cnt = 0;
      obs_g = -1;
      for (int i = 0; i < 3; i++) begin
         a[i] = '0;
         b[i] = '0;
         s[i] = 1'b0;
      end
      @(posedge clk);
      #1;
      do_reset();
      vld = '0;

      a[0] = 35'd5; b[0] = 35'd3; s[0] = 1'b0; vld[0] = 1'b1;
      cycle();
      chk("add_grant", 64'(obs_g), 64'd0);
      cycle();
      chk("add_valid", 64'(rsp_valid), 64'd1);
      chk("add_res", 64'(rsp_res), 64'd8);
      chk("add_id", 64'(rsp_id), 64'd0);
      cycle();

      a[1] = '0; b[1] = 35'd1; s[1] = 1'b1; vld[1] = 1'b1;
      cycle();
      cycle();
      chk("sub_res", 64'(rsp_res), 64'h7_FFFF_FFFF);
      chk("sub_id", 64'(rsp_id), 64'd1);
      repeat (2) cycle();

      do_reset();
      keep = 3'b111;
      for (int i = 0; i < 3; i++) new_ops(i);
      vld = 3'b111;
      for (int i = 0; i < 6; i++) begin
         cycle();
         chk("fair_grant", 64'(obs_g), 64'(i % 3));
      end
      keep = '0;
      repeat (6) cycle();

      rsp_ready = 1'b0;
      keep = 3'b101;
      new_ops(0);
      new_ops(2);
      vld = 3'b101;
      acc_cnt = 0;
      repeat (4) cycle();
      chk("bp_accepts", 64'(acc_cnt), 64'd2);
      keep = '0;
      rsp_ready = 1'b1;
      rsp_cnt = 0;
      repeat (2) cycle();
      chk("bp_delivered", 64'(rsp_cnt), 64'd2);

      repeat (6) cycle();
      chk("idle_op1", 64'(m_op1), 64'd0);
      chk("idle_op2", 64'(m_op2), 64'd0);
      chk("idle_add", 64'(m_add), 64'd0);
      chk("idle_sub", 64'(m_sub), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);

      rsp_ready = 1'b0;
      keep = 3'b010;
      new_ops(1);
      vld = 3'b010;
      repeat (2) cycle();
      keep = '0;
      chk("pre_rst_rsp", 64'(rsp_valid), 64'd1);
      chk("pre_rst_op", 64'(m_add | m_sub), 64'd1);
      do_reset();
      vld = '0;
      rsp_ready = 1'b1;
      repeat (2) cycle();
      for (int i = 0; i < 3; i++) new_ops(i);
      vld = 3'b111;
      cycle();
      chk("rst_prio", 64'(obs_g), 64'd0);
      repeat (6) cycle();

      repeat (400) begin
         for (int i = 0; i < 3; i++)
            if (!vld[i] && $urandom_range(0, 2) == 0) begin
               new_ops(i);
               vld[i] = 1'b1;
            end
         rsp_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      rsp_ready = 1'b1;
      repeat (12) cycle();
      chk("final_busy", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
